// File: rtl/pipeline_latealu.sv
// Late-ALU execution unit: single-cycle shifts plus an iterative mult/div
// engine that owns HI/LO and stalls HI/LO-class requests while it is busy.
module pipeline_latealu (
  input  logic        clk,
  input  logic        rst,
  input  logic        latealu_enable,
  input  logic [5:0]  latealu_op,
  input  logic [31:0] latealu_a0,
  input  logic [31:0] latealu_a1,
  input  logic [4:0]  rd_index_in,
  output logic [4:0]  rd_index,
  output logic [31:0] result,
  output logic        result_valid,
  output logic        stall,
  output logic [2:0]  exception
);

  // state  | meaning
  // S_IDLE | engine free, HI/LO-class requests accepted
  // S_MUL  | shift-add multiply, one multiplier bit per cycle
  // S_DIV  | restoring divide, one quotient bit per cycle
  // S_FIX  | sign fix-up and HI/LO write
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  localparam logic [5:0] OP_SLL  = 6'd1,  OP_SRL  = 6'd2,  OP_SRA  = 6'd3;
  localparam logic [5:0] OP_MULT = 6'd4,  OP_MULTU = 6'd5, OP_DIV = 6'd6, OP_DIVU = 6'd7;
  localparam logic [5:0] OP_MFHI = 6'd8,  OP_MFLO = 6'd9;
  localparam logic [5:0] OP_MTHI = 6'd10, OP_MTLO = 6'd11;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [63:0] acc_q, acc_d;     // mult accumulator / div partial remainder
  logic [63:0] mcand_q, mcand_d; // shifted multiplicand / divisor in [31:0]
  logic [31:0] opb_q, opb_d;     // multiplier shifting out / dividend->quotient
  logic [31:0] orig_a0_q, orig_a0_d;
  logic        neg_q, neg_d, rem_neg_q, rem_neg_d, is_div_q, is_div_d;
  logic [4:0]  rdi_q, rdi_d;
  logic [31:0] res_q, res_d;
  logic        rv_q, rv_d;
  logic [2:0]  exc_q, exc_d;

  logic        is_hilo, accept, is_signed;
  logic [31:0] mag_a, mag_b, quot, rem;
  logic [32:0] rem_sh;
  logic [33:0] trial;
  logic [63:0] prod;

  assign is_hilo = (latealu_op >= OP_MULT) && (latealu_op <= OP_MTLO);
  assign stall   = !rst && latealu_enable && (state_q != S_IDLE) && is_hilo;
  assign accept  = latealu_enable && !stall;

  assign is_signed = (latealu_op == OP_MULT) || (latealu_op == OP_DIV);
  assign mag_a = (is_signed && latealu_a0[31]) ? 32'd0 - latealu_a0 : latealu_a0;
  assign mag_b = (is_signed && latealu_a1[31]) ? 32'd0 - latealu_a1 : latealu_a1;

  assign rem_sh = {acc_q[31:0], opb_q[31]};
  assign trial  = {1'b0, rem_sh} - {2'b00, mcand_q[31:0]};
  assign prod   = neg_q ? 64'd0 - acc_q : acc_q;
  assign quot   = neg_q ? 32'd0 - opb_q : opb_q;
  assign rem    = rem_neg_q ? 32'd0 - acc_q[31:0] : acc_q[31:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    opb_d     = opb_q;
    orig_a0_d = orig_a0_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    is_div_d  = is_div_q;
    rdi_d     = 5'd0;
    res_d     = res_q;
    rv_d      = 1'b0;
    exc_d     = 3'b000;

    case (state_q)
      S_MUL: begin
        if (opb_q[0]) acc_d = acc_q + mcand_q;
        mcand_d = {mcand_q[62:0], 1'b0};
        opb_d   = {1'b0, opb_q[31:1]};
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIX;
      end
      S_DIV: begin
        if (!trial[33]) begin
          acc_d = {31'd0, trial[32:0]};
          opb_d = {opb_q[30:0], 1'b1};
        end else begin
          acc_d = {31'd0, rem_sh};
          opb_d = {opb_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIX;
      end
      S_FIX: begin
        if (!is_div_q) begin
          hi_d = prod[63:32];
          lo_d = prod[31:0];
        end else if (mcand_q[31:0] == 32'd0) begin
          hi_d = orig_a0_q;
          lo_d = 32'hFFFF_FFFF;
        end else begin
          hi_d = rem;
          lo_d = quot;
        end
        state_d = S_IDLE;
      end
      default: ;
    endcase

    if (accept) begin
      case (latealu_op)
        OP_SLL: begin res_d = latealu_a0 << latealu_a1[4:0]; rv_d = 1'b1; rdi_d = rd_index_in; end
        OP_SRL: begin res_d = latealu_a0 >> latealu_a1[4:0]; rv_d = 1'b1; rdi_d = rd_index_in; end
        OP_SRA: begin
          res_d = $unsigned($signed(latealu_a0) >>> latealu_a1[4:0]);
          rv_d  = 1'b1;
          rdi_d = rd_index_in;
        end
        OP_MFHI: begin res_d = hi_q; rv_d = 1'b1; rdi_d = rd_index_in; end
        OP_MFLO: begin res_d = lo_q; rv_d = 1'b1; rdi_d = rd_index_in; end
        OP_MTHI: hi_d = latealu_a0;
        OP_MTLO: lo_d = latealu_a0;
        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
          is_div_d  = (latealu_op == OP_DIV) || (latealu_op == OP_DIVU);
          neg_d     = is_signed && (latealu_a0[31] ^ latealu_a1[31]);
          rem_neg_d = is_signed && latealu_a0[31];
          orig_a0_d = latealu_a0;
          acc_d     = 64'd0;
          cnt_d     = 5'd0;
          if (is_div_d) begin
            mcand_d = {32'd0, mag_b};
            opb_d   = mag_a;
            state_d = S_DIV;
          end else begin
            mcand_d = {32'd0, mag_a};
            opb_d   = mag_b;
            state_d = S_MUL;
          end
        end
        default: if (latealu_op != 6'd0) exc_d = 3'b001;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 5'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      acc_q     <= 64'd0;
      mcand_q   <= 64'd0;
      opb_q     <= 32'd0;
      orig_a0_q <= 32'd0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      is_div_q  <= 1'b0;
      rdi_q     <= 5'd0;
      res_q     <= 32'd0;
      rv_q      <= 1'b0;
      exc_q     <= 3'b000;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      opb_q     <= opb_d;
      orig_a0_q <= orig_a0_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      is_div_q  <= is_div_d;
      rdi_q     <= rdi_d;
      res_q     <= res_d;
      rv_q      <= rv_d;
      exc_q     <= exc_d;
    end
  end

  assign rd_index     = rdi_q;
  assign result       = res_q;
  assign result_valid = rv_q;
  assign exception    = exc_q;

endmodule

// File: tb/tb_pipeline_latealu.sv
// Directed self-checking bench for pipeline_latealu: shifts, HI/LO engine,
// stall window, bad op and mid-operation reset.
module tb_pipeline_latealu;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [5:0]  op;
  logic [31:0] a0, a1;
  logic [4:0]  rdi;
  logic [4:0]  rd_index;
  logic [31:0] result;
  logic        result_valid, stall;
  logic [2:0]  exception;

  int n_checks = 0;
  int n_fail   = 0;

  pipeline_latealu dut (
    .clk(clk), .rst(rst), .latealu_enable(en), .latealu_op(op),
    .latealu_a0(a0), .latealu_a1(a1), .rd_index_in(rdi),
    .rd_index(rd_index), .result(result), .result_valid(result_valid),
    .stall(stall), .exception(exception)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] r);
    en = 1'b1; op = o; a0 = x; a1 = y; rdi = r;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    en = 1'b0; op = 6'd0; a0 = 32'd0; a1 = 32'd0; rdi = 5'd0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b1; op = 6'd4; a0 = 32'd9; a1 = 32'd9; rdi = 5'd3;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stall); end
    n_checks++;
    if ({rd_index, result, result_valid, exception} !== 41'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got rd=%0d res=%h v=%b exc=%b want all 0",
               rd_index, result, result_valid, exception);
    end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_shift;
    drive(6'd1, 32'h0000_0001, 32'd4, 5'd5);
    n_checks++;
    if (result !== 32'h10 || result_valid !== 1'b1 || rd_index !== 5'd5) begin
      n_fail++;
      $display("FAIL sll got res=%h v=%b rd=%0d want 00000010 1 5", result, result_valid, rd_index);
    end
    drive(6'd3, 32'h8000_0000, 32'd31, 5'd6);
    n_checks++;
    if (result !== 32'hFFFF_FFFF || rd_index !== 5'd6) begin
      n_fail++;
      $display("FAIL sra got res=%h rd=%0d want ffffffff 6", result, rd_index);
    end
    drive(6'd2, 32'h8000_0000, 32'h0000_0024, 5'd7);
    n_checks++;
    if (result !== 32'h0800_0000 || result_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL srl got res=%h v=%b want 08000000 1", result, result_valid);
    end
    idle(1);
    n_checks++;
    if (result_valid !== 1'b0 || rd_index !== 5'd0) begin
      n_fail++;
      $display("FAIL bubble got v=%b rd=%0d want 0 0", result_valid, rd_index);
    end
  endtask

  task automatic test_mult_stall;
    int n;
    drive(6'd4, 32'hFFFF_FFFD, 32'd5, 5'd7);
    n_checks++;
    if (result_valid !== 1'b0 || rd_index !== 5'd0) begin
      n_fail++;
      $display("FAIL mult_accept got v=%b rd=%0d want 0 0", result_valid, rd_index);
    end
    en = 1'b1; op = 6'd8; a0 = 32'd0; a1 = 32'd0; rdi = 5'd8;
    #1;
    n = 0;
    while (stall && n < 50) begin
      n++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (n !== 33) begin n_fail++; $display("FAIL stall_cycles got %0d want 33", n); end
    @(posedge clk); #1;
    n_checks++;
    if (result !== 32'hFFFF_FFFF || result_valid !== 1'b1 || rd_index !== 5'd8) begin
      n_fail++;
      $display("FAIL mult_hi got res=%h v=%b rd=%0d want ffffffff 1 8", result, result_valid, rd_index);
    end
    drive(6'd9, 32'd0, 32'd0, 5'd9);
    n_checks++;
    if (result !== 32'hFFFF_FFF1 || rd_index !== 5'd9) begin
      n_fail++;
      $display("FAIL mult_lo got res=%h rd=%0d want fffffff1 9", result, rd_index);
    end
    idle(1);
  endtask

  task automatic test_div;
    drive(6'd6, 32'hFFFF_FFF9, 32'd2, 5'd1);
    idle(34);
    drive(6'd8, 32'd0, 32'd0, 5'd2);
    n_checks++;
    if (result !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_hi got %h want ffffffff", result); end
    drive(6'd9, 32'd0, 32'd0, 5'd2);
    n_checks++;
    if (result !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_lo got %h want fffffffd", result); end

    drive(6'd7, 32'd7, 32'd0, 5'd1);
    idle(34);
    drive(6'd8, 32'd0, 32'd0, 5'd2);
    n_checks++;
    if (result !== 32'd7) begin n_fail++; $display("FAIL divz_hi got %h want 00000007", result); end
    drive(6'd9, 32'd0, 32'd0, 5'd2);
    n_checks++;
    if (result !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divz_lo got %h want ffffffff", result); end

    drive(6'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd1);
    idle(34);
    drive(6'd8, 32'd0, 32'd0, 5'd2);
    n_checks++;
    if (result !== 32'd0) begin n_fail++; $display("FAIL divmin_hi got %h want 00000000", result); end
    drive(6'd9, 32'd0, 32'd0, 5'd2);
    n_checks++;
    if (result !== 32'h8000_0000) begin n_fail++; $display("FAIL divmin_lo got %h want 80000000", result); end
    idle(1);
  endtask

  task automatic test_multu_overlap;
    drive(6'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1);
    en = 1'b1; op = 6'd1; a0 = 32'd3; a1 = 32'd2; rdi = 5'd3;
    #1;
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL busy_sll_stall got %b want 0", stall); end
    @(posedge clk); #1;
    n_checks++;
    if (result !== 32'hC || result_valid !== 1'b1 || rd_index !== 5'd3) begin
      n_fail++;
      $display("FAIL busy_sll got res=%h v=%b rd=%0d want 0000000c 1 3", result, result_valid, rd_index);
    end
    drive(6'd3, 32'hF000_0000, 32'd4, 5'd4);
    n_checks++;
    if (result !== 32'hFF00_0000 || rd_index !== 5'd4) begin
      n_fail++;
      $display("FAIL busy_sra got res=%h rd=%0d want ff000000 4", result, rd_index);
    end
    idle(34);
    drive(6'd8, 32'd0, 32'd0, 5'd2);
    n_checks++;
    if (result !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_hi got %h want fffffffe", result); end
    drive(6'd9, 32'd0, 32'd0, 5'd2);
    n_checks++;
    if (result !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_lo got %h want 00000001", result); end
    idle(1);
  endtask

  task automatic test_bad_op;
    drive(6'd10, 32'h1234_5678, 32'd0, 5'd9);
    drive(6'd11, 32'h9ABC_DEF0, 32'd0, 5'd9);
    n_checks++;
    if (result_valid !== 1'b0 || rd_index !== 5'd0) begin
      n_fail++;
      $display("FAIL mtlo_wb got v=%b rd=%0d want 0 0", result_valid, rd_index);
    end
    drive(6'h3F, 32'hDEAD_BEEF, 32'd1, 5'd12);
    n_checks++;
    if (exception !== 3'b001 || result_valid !== 1'b0 || rd_index !== 5'd0) begin
      n_fail++;
      $display("FAIL bad_op got exc=%b v=%b rd=%0d want 001 0 0", exception, result_valid, rd_index);
    end
    idle(1);
    n_checks++;
    if (exception !== 3'b000) begin n_fail++; $display("FAIL exc_clear got %b want 000", exception); end
    drive(6'd8, 32'd0, 32'd0, 5'd13);
    n_checks++;
    if (result !== 32'h1234_5678 || rd_index !== 5'd13) begin
      n_fail++;
      $display("FAIL mthi_read got res=%h rd=%0d want 12345678 13", result, rd_index);
    end
    drive(6'd9, 32'd0, 32'd0, 5'd14);
    n_checks++;
    if (result !== 32'h9ABC_DEF0) begin n_fail++; $display("FAIL mtlo_read got %h want 9abcdef0", result); end
    idle(1);
  endtask

  task automatic test_reset_mid;
    drive(6'd6, 32'd100, 32'd7, 5'd1);
    idle(9);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if ({rd_index, result, result_valid, exception} !== 41'd0) begin
      n_fail++;
      $display("FAIL midrst_outputs got rd=%0d res=%h v=%b exc=%b want all 0",
               rd_index, result, result_valid, exception);
    end
    en = 1'b1; op = 6'd8; a0 = 32'd0; a1 = 32'd0; rdi = 5'd15;
    #1;
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL midrst_stall got %b want 0", stall); end
    @(posedge clk); #1;
    n_checks++;
    if (result !== 32'd0 || result_valid !== 1'b1 || rd_index !== 5'd15) begin
      n_fail++;
      $display("FAIL midrst_hi got res=%h v=%b rd=%0d want 00000000 1 15", result, result_valid, rd_index);
    end
    drive(6'd9, 32'd0, 32'd0, 5'd16);
    n_checks++;
    if (result !== 32'd0) begin n_fail++; $display("FAIL midrst_lo got %h want 00000000", result); end
    idle(1);
  endtask

  initial begin
    test_reset();
    test_shift();
    test_mult_stall();
    test_div();
    test_multu_overlap();
    test_bad_op();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
